// File: rtl/fft_out_reorder.sv
// Collects bin-tagged butterfly results into a two-bank frame buffer
// and replays each complete frame in natural bin order.
module fft_out_reorder #(
   parameter int DATA_W = 50,
   parameter int N      = 8,
   parameter int IDX_W  = 3,
   parameter bit BITREV = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic [IDX_W-1:0]  in_idx_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [IDX_W-1:0]  out_idx_o,
   output logic              out_last_o,
   output logic              overflow_o,
   output logic              dup_err_o
);

   typedef enum logic {
      IDLE,
      SEND
   } drn_state_t;

   function automatic logic [IDX_W-1:0] bit_rev(
      input logic [IDX_W-1:0] v
   );
      for (int i = 0; i < IDX_W; i++)
         bit_rev[i] = v[IDX_W-1-i];
   endfunction

   logic [DATA_W-1:0]   mem [2][N];
   logic [1:0][N-1:0]   mask_q;
   logic [1:0]          full_q;
   logic                cap_bank_q;
   logic                drn_bank_q;
   logic                overflow_q;
   logic                dup_err_q;

   drn_state_t          state_q;
   drn_state_t          state_d;
   logic                out_valid_q;
   logic                out_valid_d;
   logic [DATA_W-1:0]   out_data_q;
   logic [DATA_W-1:0]   out_data_d;
   logic [IDX_W-1:0]    out_idx_q;
   logic [IDX_W-1:0]    out_idx_d;
   logic                out_last_q;
   logic                out_last_d;
   logic                drn_free;

   logic [IDX_W-1:0]    wr_idx;
   logic [N-1:0]        wr_bit;
   logic [N-1:0]        mask_new;
   logic                cap_ok;
   logic                cap_done;
   logic                cap_dup;
   logic                cap_drop;
   logic [IDX_W-1:0]    nxt_idx;

   // capture path: a full cap bank means both banks are busy
   always_comb begin
      wr_idx   = BITREV ? bit_rev(in_idx_i) : in_idx_i;
      wr_bit   = {{(N-1){1'b0}}, 1'b1} << wr_idx;
      cap_ok   = in_valid_i & ~full_q[cap_bank_q];
      cap_drop = in_valid_i & full_q[cap_bank_q];
      mask_new = mask_q[cap_bank_q] | wr_bit;
      cap_dup  = cap_ok & (|(mask_q[cap_bank_q] & wr_bit));
      cap_done = cap_ok & (&mask_new);
   end

   always_ff @(posedge clk_i) begin
      if (cap_ok)
         mem[cap_bank_q][wr_idx] <= in_data_i;
   end

   // drain only frees a full bank, capture only writes a non-full one,
   // so the two never touch the same bank at one edge
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mask_q     <= '0;
         full_q     <= '0;
         cap_bank_q <= 1'b0;
         drn_bank_q <= 1'b0;
         overflow_q <= 1'b0;
         dup_err_q  <= 1'b0;
      end else begin
         if (drn_free) begin
            mask_q[drn_bank_q] <= '0;
            full_q[drn_bank_q] <= 1'b0;
            drn_bank_q         <= ~drn_bank_q;
         end
         if (cap_ok) begin
            mask_q[cap_bank_q] <= mask_new;
            if (cap_done) begin
               full_q[cap_bank_q] <= 1'b1;
               cap_bank_q         <= ~cap_bank_q;
            end
         end
         if (cap_dup)
            dup_err_q <= 1'b1;
         if (cap_drop)
            overflow_q <= 1'b1;
      end
   end

   assign nxt_idx = out_idx_q + IDX_W'(1);

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      drn_free    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (full_q[drn_bank_q]) begin
               state_d     = SEND;
               out_valid_d = 1'b1;
               out_idx_d   = '0;
               out_data_d  = mem[drn_bank_q][0];
               out_last_d  = 1'b0;
            end
         end
         SEND: begin
            if (out_ready_i) begin
               if (out_last_q) begin
                  drn_free   = 1'b1;
                  out_idx_d  = '0;
                  out_last_d = 1'b0;
                  if (full_q[~drn_bank_q]) begin
                     out_data_d = mem[~drn_bank_q][0];
                  end else begin
                     state_d     = IDLE;
                     out_valid_d = 1'b0;
                  end
               end else begin
                  out_idx_d  = nxt_idx;
                  out_data_d = mem[drn_bank_q][nxt_idx];
                  out_last_d = (nxt_idx == IDX_W'(N - 1));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_idx_o   = out_idx_q;
   assign out_last_o  = out_last_q;
   assign overflow_o  = overflow_q;
   assign dup_err_o   = dup_err_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder; a BITREV=1 copy runs in lockstep
// on the same stimulus so both index mappings are exercised.
module tb_fft_out_reorder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [49:0] in_data = '0;
   logic [2:0]  in_idx = '0;
   logic        out_ready = 1'b0;

   logic        out_valid, out_last, overflow, dup_err;
   logic [49:0] out_data;
   logic [2:0]  out_idx;
   logic        br_valid, br_last, br_overflow, br_dup_err;
   logic [49:0] br_data;
   logic [2:0]  br_idx;

   int n_checks = 0;
   int n_fail   = 0;
   logic [49:0] exp_d [16];

   always #5 clk = ~clk;

   fft_out_reorder #(.DATA_W(50), .N(8), .IDX_W(3), .BITREV(1'b0)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_idx_i(in_idx),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_data_o(out_data), .out_idx_o(out_idx),
      .out_last_o(out_last), .overflow_o(overflow),
      .dup_err_o(dup_err)
   );

   fft_out_reorder #(.DATA_W(50), .N(8), .IDX_W(3), .BITREV(1'b1)) dut_br (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_idx_i(in_idx),
      .out_valid_o(br_valid), .out_ready_i(out_ready),
      .out_data_o(br_data), .out_idx_o(br_idx),
      .out_last_o(br_last), .overflow_o(br_overflow),
      .dup_err_o(br_dup_err)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] rev3(input logic [2:0] v);
      return {v[0], v[1], v[2]};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_data"}, 64'(out_data), 64'd0);
      check({tag, "_idx"}, 64'(out_idx), 64'd0);
      check({tag, "_last"}, 64'(out_last), 64'd0);
      check({tag, "_ovf"}, 64'(overflow), 64'd0);
      check({tag, "_dup"}, 64'(dup_err), 64'd0);
      check({tag, "_br_valid"}, 64'(br_valid), 64'd0);
   endtask

   task automatic send(input logic [2:0] idx, input logic [49:0] d);
      @(negedge clk);
      in_valid = 1'b1;
      in_idx = idx;
      in_data = d;
   endtask

   task automatic end_in();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // mode 0: ready always high, no bubbles allowed; mode 1: ready 1,0,0,...
   task automatic drain(input int nb, input int mode);
      int k = 0;
      int cyc = 0;
      bit started = 1'b0;
      logic [2:0] b;
      while (k < nb && cyc < 200) begin
         @(negedge clk);
         cyc++;
         out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 1);
         if (started && mode == 0)
            check("no_bubble", 64'(out_valid), 64'd1);
         if (out_valid) begin
            started = 1'b1;
            b = 3'(k % 8);
            check("out_idx", 64'(out_idx), 64'(b));
            check("out_data", 64'(out_data), 64'(exp_d[k]));
            check("out_last", 64'(out_last), 64'(b == 3'd7));
            check("br_valid", 64'(br_valid), 64'd1);
            check("br_data", 64'(br_data),
                  64'(exp_d[(k / 8) * 8 + int'(rev3(b))]));
            if (out_ready)
               k++;
         end
      end
      if (k < nb)
         check("drain_timeout", 64'(k), 64'(nb));
   endtask

   task automatic drain_done();
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_after", 64'(out_valid), 64'd0);
   endtask

   initial begin
      int k;
      int cyc;
      logic [2:0] order [8];

      do_reset();
      check_zero("reset");

      // natural order
      for (int i = 0; i < 8; i++) begin
         send(3'(i), 50'h10 + 50'(i));
         exp_d[i] = 50'h10 + 50'(i);
      end
      end_in();
      check("lat0", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("lat1", 64'(out_valid), 64'd1);
      drain(8, 0);
      drain_done();
      check("nat_ovf", 64'(overflow), 64'd0);
      check("nat_dup", 64'(dup_err), 64'd0);

      // scrambled arrival order
      order = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
      for (int i = 0; i < 8; i++) begin
         send(order[i], 50'hA0 + 50'(order[i]));
         exp_d[i] = 50'hA0 + 50'(i);
      end
      end_in();
      drain(8, 0);
      drain_done();

      // backpressure
      for (int i = 0; i < 8; i++) begin
         send(3'(i), 50'h50 + 50'(i));
         exp_d[i] = 50'h50 + 50'(i);
      end
      end_in();
      drain(8, 1);
      drain_done();

      // ping-pong with third frame dropped
      for (int i = 0; i < 24; i++) begin
         send(3'(i % 8), 50'(((i / 8) + 1) * 'h100 + (i % 8)));
         if (i == 16)
            check("ovf_before", 64'(overflow), 64'd0);
         if (i == 17)
            check("ovf_after", 64'(overflow), 64'd1);
      end
      for (int i = 0; i < 16; i++)
         exp_d[i] = 50'(((i / 8) + 1) * 'h100 + (i % 8));
      end_in();
      check("pp_ovf", 64'(overflow), 64'd1);
      check("pp_br_ovf", 64'(br_overflow), 64'd1);
      drain(16, 0);
      drain_done();

      // duplicate index
      do_reset();
      check_zero("reset2");
      send(3'd3, 50'h1);
      send(3'd3, 50'h2);
      for (int i = 0; i < 8; i++) begin
         if (i != 3)
            send(3'(i), 50'h30 + 50'(i));
         exp_d[i] = (i == 3) ? 50'h2 : 50'h30 + 50'(i);
         if (i == 6) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            check("dup_not_full", 64'(out_valid), 64'd0);
         end
      end
      end_in();
      check("dup_flag", 64'(dup_err), 64'd1);
      check("dup_br_flag", 64'(br_dup_err), 64'd1);
      drain(8, 0);
      drain_done();
      check("dup_sticky", 64'(dup_err), 64'd1);

      // reset mid-drain
      do_reset();
      for (int i = 0; i < 8; i++)
         send(3'(i), 50'h40 + 50'(i));
      end_in();
      k = 0;
      cyc = 0;
      while (k < 5 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         out_ready = 1'b1;
         if (out_valid) begin
            check("mid_idx", 64'(out_idx), 64'(k));
            check("mid_data", 64'(out_data), 64'h40 + 64'(k));
            k++;
         end
      end
      if (k < 5)
         check("mid_timeout", 64'(k), 64'd5);
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_zero("mid_reset");
      for (int i = 0; i < 8; i++) begin
         send(3'(i), 50'h60 + 50'(i));
         exp_d[i] = 50'h60 + 50'(i);
      end
      end_in();
      drain(8, 0);
      drain_done();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
Output-side collector for the 8-point butterfly_stage. It captures result samples tagged with a bin index (the final_stage / final_num pair) in any arrival order and stores them in a two-bank frame buffer. Complete frames are emitted as a natural-order stream (bin 0..7) with a valid/ready handshake. It is the reading end of the stream that the input sequencer writes into butterfly_stage.

Parameters:
DATA_W, 50, complex sample width; [DATA_W-1:DATA_W/2] real, [DATA_W/2-1:0] imag, both two's complement
N, 8, points per frame (power of two)
IDX_W, 3, log2(N)
BITREV, 0, 1 = bit-reverse in_idx_i before storing; 0 = store as given

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous, active-high reset
in_valid_i  in  1  in_data_i/in_idx_i valid this cycle; no backpressure
in_data_i  in  DATA_W  result sample
in_idx_i  in  IDX_W  bin index of in_data_i
out_valid_o  out  1  out_data_o/out_idx_o valid
out_ready_i  in  1  downstream accepts when high with out_valid_o
out_data_o  out  DATA_W  sample, natural bin order
out_idx_o  out  IDX_W  bin of out_data_o
out_last_o  out  1  high with bin N-1
overflow_o  out  1  sticky: a sample was dropped, no free bank
dup_err_o  out  1  sticky: an index was written twice within one frame

Behaviour:
- Reset: clock-synchronous, active-high. All outputs are 0, both bank masks are cleared, cap_bank=0, drn_bank=0, drain FSM is IDLE. Reset mid-frame or mid-drain discards all buffered data. Reset takes priority over every other event.
- Storage: 2 banks x N x DATA_W registers. Each bank has an N-bit written mask and a full flag.
- Capture, per cycle with in_valid_i=1:
  - If cap_bank is not full: write mem[cap_bank][idx], where idx = BITREV ? bitrev(in_idx_i) : in_idx_i, and set mask[idx].
  - If mask[idx] was already set: overwrite the data, leave the mask unchanged, set dup_err_o.
  - When the write completes the mask (all ones): set full[cap_bank] at that edge, and toggle cap_bank at the same edge.
  - If cap_bank is full (both banks busy): drop the sample and set overflow_o. No memory or mask change.
- Drain FSM:
  - IDLE: go to SEND when full[drn_bank]=1. Load rd_idx=0 and drive out_valid_o=1 from the next cycle. Minimum latency is 1 cycle from the edge that completes the frame to out_valid_o=1.
  - SEND: out_data_o=mem[drn_bank][rd_idx], out_idx_o=rd_idx, out_last_o=(rd_idx==N-1).
    - Outputs are registered and held stable while out_valid_o=1 and out_ready_i=0.
    - On out_valid_o & out_ready_i, advance rd_idx. Back-to-back transfers run at 1 per cycle with no bubbles.
    - When the last bin is accepted: clear mask/full of drn_bank and toggle drn_bank. If the new drn_bank is already full, the next frame's bin 0 is presented in the very next cycle. Otherwise return to IDLE with out_valid_o=0.
- Same cycle free and capture: a bank freed at an edge is visible to capture only from the following cycle. A sample arriving in the freeing cycle while cap_bank is full is dropped and sets overflow.
- Frames always drain in completion order. cap_bank and drn_bank alternate strictly.
- out_valid_o never deasserts without a handshake except by reset.
- Sticky flags clear only on reset.

Test Plan:
- Natural order: reset, then write idx 0..7 with data 50'h10+idx -> out_valid_o rises 1 cycle after the idx-7 write. Outputs idx 0..7 with data 50'h10..50'h17 on 8 consecutive cycles (out_ready_i=1). out_last_o only on idx 7. Flags stay 0.
- Scrambled order: BITREV=0, write idx 0,4,2,6,1,5,3,7 with data 50'hA0+idx -> output idx 0..7 with data 50'hA0..50'hA7. With BITREV=1 and in_idx_i 0..7 -> output bin k carries the sample sent with idx bitrev(k), e.g. bin 1 = data sent at idx 4.
- Backpressure: toggle out_ready_i 1,0,0,1,... during drain -> data/idx hold while ready=0. All 8 bins are delivered exactly once, in order.
- Ping-pong and overflow: out_ready_i=0, write 3 full frames (24 samples) -> frames 1 and 2 are buffered and overflow_o=1 from the edge of frame 3's first sample. Raise ready -> 16 outputs, frame 1 then frame 2, with no bubble between them.
- Duplicate: write idx 3 twice (data 1, then 2) plus the other 7 indices -> dup_err_o=1 and bin 3 outputs 2. Frame completes after 8 distinct indices.
- Reset mid-drain: assert rst_i for 1 cycle after bin 4 is accepted -> next cycle all outputs are 0. A new complete frame then drains from bin 0 with correct data.
